// File: rtl/ram_access_ctrl.sv
`timescale 1ns/1ps
// ram_access_ctrl
// Load/store initiator for the single-port data RAM. It accepts byte-addressed
// byte/halfword/word requests over a valid/ready handshake and drives the
// RAM's word-addressed port. Sub-word stores use read-modify-write, and
// sub-word loads are extracted and then zero- or sign-extended. Each request
// ends in a one-cycle response pulse that carries the load data or an error flag.
//
// Optional feature macro: RAM_ACCESS_BOUNDS_CHECK_EN
//   When defined, a word index >= ENTRIES is rejected as an error.
//
// Ports
//   Clk, Rst       clock (rising edge), asynchronous active-low reset
//   Req_Valid/Ready request handshake; Ready is high only while idle
//   Req_Wr         1 = store, 0 = load
//   Req_Size       00 byte, 01 halfword, 10 word, 11 error
//   Req_Signed     sign-extend sub-word loads
//   Req_Addr       byte address
//   Req_WData      store data, right-aligned
//   Rsp_Valid      one-cycle response pulse
//   Rsp_RData      load result (0 for stores and errors)
//   Rsp_Err        request rejected
//   Ram_A/WD/WE    RAM word address, write data, write enable
//   Ram_RD         RAM read data, combinational from Ram_A
module ram_access_ctrl #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned ENTRIES    = 100,
  parameter int unsigned ADDR_W     = $clog2(ENTRIES)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic                  Req_Wr,
  input  logic [1:0]            Req_Size,
  input  logic                  Req_Signed,
  input  logic [ADDR_W+1:0]     Req_Addr,
  input  logic [WORD_WIDTH-1:0] Req_WData,
  output logic                  Rsp_Valid,
  output logic [WORD_WIDTH-1:0] Rsp_RData,
  output logic                  Rsp_Err,
  output logic [ADDR_W-1:0]     Ram_A,
  output logic [WORD_WIDTH-1:0] Ram_WD,
  output logic                  Ram_WE,
  input  logic [WORD_WIDTH-1:0] Ram_RD
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic [ADDR_W+1:0]       addr_q, addr_d;
  logic [1:0]              size_q, size_d;
  logic                    signed_q, signed_d;
  logic                    wr_q, wr_d;
  logic                    err_q, err_d;
  logic [WORD_WIDTH-1:0]   wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0]   rd_word_q, rd_word_d;
  logic [ADDR_W-1:0]       ram_a_q, ram_a_d;
  logic [WORD_WIDTH-1:0]   ram_wd_q, ram_wd_d;
  logic                    ram_we_q, ram_we_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [WORD_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic                    accept;
  logic                    req_err;
  logic [WORD_WIDTH-1:0]   load_data;
  logic [WORD_WIDTH-1:0]   merge_data;

  assign Req_Ready = ready_q;
  assign Rsp_Valid = rsp_valid_q;
  assign Rsp_RData = rsp_rdata_q;
  assign Rsp_Err   = rsp_err_q;
  assign Ram_A     = ram_a_q;
  assign Ram_WD    = ram_wd_q;
  assign Ram_WE    = ram_we_q;

  assign accept = Req_Valid && ready_q && (state_q == IDLE);

  // Misalignment / size (and optionally bounds) check on the incoming request
  always_comb begin
    req_err = 1'b0;
    case (Req_Size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = Req_Addr[0];
      SZ_WORD: req_err = (Req_Addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
`ifdef RAM_ACCESS_BOUNDS_CHECK_EN
    if (32'(Req_Addr[ADDR_W+1:2]) >= ENTRIES) begin
      req_err = 1'b1;
    end
`else
`endif
  end

  // Lane extraction and extension of the captured word for loads
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    load_data = '0;
    case (addr_q[1:0])
      2'd0:    b = rd_word_q[7:0];
      2'd1:    b = rd_word_q[15:8];
      2'd2:    b = rd_word_q[23:16];
      default: b = rd_word_q[31:24];
    endcase
    h = addr_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    case (size_q)
      SZ_BYTE: load_data = {{24{b[7] & signed_q}}, b};
      SZ_HALF: load_data = {{16{h[15] & signed_q}}, h};
      SZ_WORD: load_data = rd_word_q;
      default: load_data = '0;
    endcase
  end

  // Lane replacement of the captured word for stores
  always_comb begin
    merge_data = rd_word_q;
    case (size_q)
      SZ_BYTE: begin
        case (addr_q[1:0])
          2'd0:    merge_data = {rd_word_q[31:8], wdata_q[7:0]};
          2'd1:    merge_data = {rd_word_q[31:16], wdata_q[7:0], rd_word_q[7:0]};
          2'd2:    merge_data = {rd_word_q[31:24], wdata_q[7:0], rd_word_q[15:0]};
          default: merge_data = {wdata_q[7:0], rd_word_q[23:0]};
        endcase
      end
      SZ_HALF: begin
        merge_data = addr_q[1] ? {wdata_q[15:0], rd_word_q[15:0]}
                               : {rd_word_q[31:16], wdata_q[15:0]};
      end
      default: merge_data = wdata_q;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    signed_d    = signed_q;
    wr_d        = wr_q;
    err_d       = err_q;
    wdata_d     = wdata_q;
    rd_word_d   = rd_word_q;
    ram_a_d     = ram_a_q;
    ram_wd_d    = ram_wd_q;
    ram_we_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = Req_Addr;
          size_d   = Req_Size;
          signed_d = Req_Signed;
          wr_d     = Req_Wr;
          err_d    = req_err;
          wdata_d  = Req_WData;
          ram_a_d  = Req_Addr[ADDR_W+1:2];
          if (req_err) begin
            state_d = RESP;
          end else if (Req_Wr && (Req_Size == SZ_WORD)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        rd_word_d = Ram_RD;
        state_d   = wr_q ? WRITE : RESP;
      end
      WRITE: begin
        state_d = RESP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs lag the state by one register stage
    if (state_q == WRITE) begin
      ram_we_d = 1'b1;
      ram_wd_d = merge_data;
    end
    if (state_q == RESP) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err_q;
      rsp_rdata_d = (!err_q && !wr_q) ? load_data : '0;
    end

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      rd_word_q   <= '0;
      ram_a_q     <= '0;
      ram_wd_q    <= '0;
      ram_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      wr_q        <= wr_d;
      err_q       <= err_d;
      wdata_q     <= wdata_d;
      rd_word_q   <= rd_word_d;
      ram_a_q     <= ram_a_d;
      ram_wd_q    <= ram_wd_d;
      ram_we_q    <= ram_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
`timescale 1ns/1ps
// Directed bench for ram_access_ctrl with a behavioral RAM model.
module tb_ram_access_ctrl;

  localparam int unsigned ADDR_W = 7;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Req_Valid = 1'b0;
  logic        Req_Ready;
  logic        Req_Wr = 1'b0;
  logic [1:0]  Req_Size = 2'b00;
  logic        Req_Signed = 1'b0;
  logic [8:0]  Req_Addr = '0;
  logic [31:0] Req_WData = '0;
  logic        Rsp_Valid;
  logic [31:0] Rsp_RData;
  logic        Rsp_Err;
  logic [6:0]  Ram_A;
  logic [31:0] Ram_WD;
  logic        Ram_WE;
  logic [31:0] Ram_RD;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  int rsp_cnt = 0;
  logic [6:0] last_we_a = '0;

  logic [31:0] mem [0:127];

  ram_access_ctrl dut (
    .Clk(Clk), .Rst(Rst),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Wr(Req_Wr),
    .Req_Size(Req_Size), .Req_Signed(Req_Signed), .Req_Addr(Req_Addr),
    .Req_WData(Req_WData),
    .Rsp_Valid(Rsp_Valid), .Rsp_RData(Rsp_RData), .Rsp_Err(Rsp_Err),
    .Ram_A(Ram_A), .Ram_WD(Ram_WD), .Ram_WE(Ram_WE), .Ram_RD(Ram_RD)
  );

  always #5 Clk = ~Clk;

  assign Ram_RD = mem[Ram_A];

  always @(posedge Clk) begin
    if (Ram_WE) begin
      mem[Ram_A] <= Ram_WD;
      last_we_a  <= Ram_A;
      we_cnt     <= we_cnt + 1;
    end
    if (Rsp_Valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request; return response data, error flag and latency in edges
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [8:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    rd = '0;
    er = 1'b0;
    @(negedge Clk);
    while (!Req_Ready && n < 10) begin
      @(negedge Clk);
      n++;
    end
    if (!Req_Ready) check("ready_timeout", 32'(Req_Ready), 32'd1);
    Req_Valid = 1'b1; Req_Wr = wr; Req_Size = sz; Req_Signed = sg;
    Req_Addr = addr; Req_WData = wd;
    @(posedge Clk);
    #1;
    Req_Valid = 1'b0; Req_Wr = ~wr; Req_Size = 2'b11; Req_Signed = ~sg;
    Req_Addr = 9'h1FF; Req_WData = 32'hDEADBEEF;
    lat = 0;
    do begin
      @(posedge Clk);
      #1;
      lat++;
    end while (!Rsp_Valid && lat < 10);
    if (Rsp_Valid) begin
      rd = Rsp_RData;
      er = Rsp_Err;
    end else begin
      check("rsp_timeout", 32'(Rsp_Valid), 32'd1);
      lat = 99;
    end
    @(posedge Clk);
    #1;
    check("rsp_one_cycle", 32'(Rsp_Valid), 32'd0);
  endtask

  task automatic xfer(input string tag, input logic wr, input logic [1:0] sz,
                      input logic sg, input logic [8:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_lat, input int exp_we);
    int w0;
    logic [31:0] rd;
    logic er;
    int lat;
    w0 = we_cnt;
    do_req(wr, sz, sg, addr, wd, rd, er, lat);
    check({tag, "_err"}, 32'(er), 32'(exp_err));
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_we"}, 32'(we_cnt - w0), 32'(exp_we));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0;
    int r0;
    logic [31:0] rd;
    logic er;
    int lat;

    // Reset values
    #1;
    check("rst_ready", 32'(Req_Ready), 32'd0);
    check("rst_ram_a", 32'(Ram_A), 32'd0);
    check("rst_ram_wd", Ram_WD, 32'd0);
    check("rst_ram_we", 32'(Ram_WE), 32'd0);
    check("rst_rsp_valid", 32'(Rsp_Valid), 32'd0);
    check("rst_rsp_rdata", Rsp_RData, 32'd0);
    check("rst_rsp_err", 32'(Rsp_Err), 32'd0);
    #2;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    check("ready_after_rst", 32'(Req_Ready), 32'd1);

    // Word store then load at 0
    xfer("st_w0", 1'b1, 2'b10, 1'b0, 9'h000, 32'h00000002, 32'h0, 1'b0, 2, 1);
    check("st_w0_addr", 32'(last_we_a), 32'd0);
    xfer("ld_w0", 1'b0, 2'b10, 1'b0, 9'h000, 32'h0, 32'h00000002, 1'b0, 2, 0);

    // Sub-word read-modify-write and extraction on word 1
    xfer("st_w4", 1'b1, 2'b10, 1'b0, 9'h004, 32'h11223344, 32'h0, 1'b0, 2, 1);
    xfer("st_b5", 1'b1, 2'b00, 1'b0, 9'h005, 32'hFFFFFFAA, 32'h0, 1'b0, 3, 1);
    check("st_b5_addr", 32'(last_we_a), 32'd1);
    xfer("ld_w4", 1'b0, 2'b10, 1'b1, 9'h004, 32'h0, 32'h1122AA44, 1'b0, 2, 0);
    xfer("ld_sb5", 1'b0, 2'b00, 1'b1, 9'h005, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0);
    xfer("ld_ub5", 1'b0, 2'b00, 1'b0, 9'h005, 32'h0, 32'h000000AA, 1'b0, 2, 0);
    xfer("ld_sh6", 1'b0, 2'b01, 1'b1, 9'h006, 32'h0, 32'h00001122, 1'b0, 2, 0);
    xfer("st_h6", 1'b1, 2'b01, 1'b0, 9'h006, 32'h0000BEEF, 32'h0, 1'b0, 3, 1);
    xfer("ld_w4b", 1'b0, 2'b10, 1'b0, 9'h004, 32'h0, 32'hBEEFAA44, 1'b0, 2, 0);
    xfer("ld_sh6b", 1'b0, 2'b01, 1'b1, 9'h006, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 0);
    xfer("ld_uh4", 1'b0, 2'b01, 1'b0, 9'h004, 32'h0, 32'h0000AA44, 1'b0, 2, 0);
    xfer("ld_sb7", 1'b0, 2'b00, 1'b1, 9'h007, 32'h0, 32'hFFFFFFBE, 1'b0, 2, 0);
    xfer("st_b4", 1'b1, 2'b00, 1'b0, 9'h004, 32'h00000001, 32'h0, 1'b0, 3, 1);
    xfer("ld_w4c", 1'b0, 2'b10, 1'b0, 9'h004, 32'h0, 32'hBEEFAA01, 1'b0, 2, 0);

    // Error cases
    xfer("err_h3", 1'b0, 2'b01, 1'b1, 9'h003, 32'h0, 32'h0, 1'b1, 1, 0);
    xfer("err_w6", 1'b1, 2'b10, 1'b0, 9'h006, 32'hCAFEF00D, 32'h0, 1'b1, 1, 0);
    xfer("err_sz3", 1'b1, 2'b11, 1'b0, 9'h004, 32'h12345678, 32'h0, 1'b1, 1, 0);
    xfer("ld_w4d", 1'b0, 2'b10, 1'b0, 9'h004, 32'h0, 32'hBEEFAA01, 1'b0, 2, 0);

    // Index 100 (byte address 400)
`ifdef RAM_ACCESS_BOUNDS_CHECK_EN
    xfer("bounds", 1'b0, 2'b10, 1'b0, 9'd400, 32'h0, 32'h0, 1'b1, 1, 0);
`else
    w0 = we_cnt;
    do_req(1'b0, 2'b10, 1'b0, 9'd400, 32'h0, rd, er, lat);
    check("nobounds_err", 32'(er), 32'd0);
    check("nobounds_lat", 32'(lat), 32'd2);
    check("nobounds_ram_a", 32'(Ram_A), 32'd100);
`endif

    // Reset during READ of a sub-word store
    xfer("st_w8", 1'b1, 2'b10, 1'b0, 9'h008, 32'h55667788, 32'h0, 1'b0, 2, 1);
    @(negedge Clk);
    Req_Valid = 1'b1; Req_Wr = 1'b1; Req_Size = 2'b00; Req_Signed = 1'b0;
    Req_Addr = 9'h009; Req_WData = 32'h00000011;
    @(posedge Clk);
    #1;
    Req_Valid = 1'b0;
    w0 = we_cnt;
    r0 = rsp_cnt;
    Rst = 1'b0;
    #2;
    check("rstmid_we", 32'(Ram_WE), 32'd0);
    check("rstmid_ready", 32'(Req_Ready), 32'd0);
    check("rstmid_valid", 32'(Rsp_Valid), 32'd0);
    Rst = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    check("rstmid_no_write", 32'(we_cnt - w0), 32'd0);
    check("rstmid_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    check("rstmid_ready_back", 32'(Req_Ready), 32'd1);
    xfer("ld_w8", 1'b0, 2'b10, 1'b0, 9'h008, 32'h0, 32'h55667788, 1'b0, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
